// File: rtl/multi_tick_timer.sv
// multi_tick_timer: CHANNELS independent programmable tick generators on one clock.
// Each channel counts down a period of P+1 cycles and emits a one-cycle tick
// strobe (used as a clock enable), running/expired status and optionally a
// square wave that toggles on every tick. Channels run periodically or as
// one-shot timers.
// Optional feature macro: MULTI_TICK_TIMER_SQUARE_EN builds the square-wave
// toggle flops; without it `square` is tied low.
module multi_tick_timer #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned WIDTH          = 24,
    parameter int unsigned DEFAULT_PERIOD = 12_499_999,
    localparam int unsigned CHAN_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock_25mhz,
    input  logic                reset_n,
    input  logic                cfg_we,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic                cfg_mode,
    input  logic [CHANNELS-1:0] start,
    input  logic [CHANNELS-1:0] stop,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] square,
    output logic [CHANNELS-1:0] running,
    output logic [CHANNELS-1:0] expired
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] RESET_PERIOD = WIDTH'(DEFAULT_PERIOD);

    // Registered per-channel state
    state_e               state_q    [CHANNELS];
    logic [WIDTH-1:0]     cnt_q      [CHANNELS];
    logic [WIDTH-1:0]     per_sh_q   [CHANNELS];
    logic [CHANNELS-1:0]  mode_sh_q;
    logic [CHANNELS-1:0]  mode_act_q;
    logic [CHANNELS-1:0]  tick_q;
    logic [CHANNELS-1:0]  run_q;
    logic [CHANNELS-1:0]  exp_q;

    // Next-state values
    state_e               state_d    [CHANNELS];
    logic [WIDTH-1:0]     cnt_d      [CHANNELS];
    logic [WIDTH-1:0]     per_sh_d   [CHANNELS];
    logic [CHANNELS-1:0]  mode_sh_d;
    logic [CHANNELS-1:0]  mode_act_d;
    logic [CHANNELS-1:0]  tick_d;
    logic [CHANNELS-1:0]  run_d;
    logic [CHANNELS-1:0]  exp_d;

`ifdef MULTI_TICK_TIMER_SQUARE_EN
    logic [CHANNELS-1:0]  sq_q;
    logic [CHANNELS-1:0]  sq_d;
`endif

    // Shadow values as seen this cycle, with a same-cycle config write forwarded
    logic [WIDTH-1:0]     per_new_c  [CHANNELS];
    logic [CHANNELS-1:0]  mode_new_c;

    // Config write decode; out-of-range channel numbers match no channel
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            per_new_c[i]  = per_sh_q[i];
            mode_new_c[i] = mode_sh_q[i];
            if (cfg_we && (cfg_chan == CHAN_W'(i))) begin
                per_new_c[i]  = cfg_period;
                mode_new_c[i] = cfg_mode;
            end
        end
    end

    // Per-channel next-state and output logic; stop beats start beats counting
    always_comb begin
        mode_sh_d  = mode_new_c;
        mode_act_d = mode_act_q;
        tick_d     = '0;
        exp_d      = exp_q;
        run_d      = '0;
`ifdef MULTI_TICK_TIMER_SQUARE_EN
        sq_d       = sq_q;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            per_sh_d[i] = per_new_c[i];
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];

            if (stop[i]) begin
                state_d[i] = S_IDLE;
                cnt_d[i]   = '0;
                exp_d[i]   = 1'b0;
`ifdef MULTI_TICK_TIMER_SQUARE_EN
                sq_d[i]    = 1'b0;
`endif
            end else if (start[i]) begin
                // Start or restart: an aborted period produces no tick
                state_d[i]    = S_RUN;
                cnt_d[i]      = per_new_c[i];
                mode_act_d[i] = mode_new_c[i];
                exp_d[i]      = 1'b0;
            end else if (state_q[i] == S_RUN) begin
                if (cnt_q[i] == '0) begin
                    tick_d[i] = 1'b1;
`ifdef MULTI_TICK_TIMER_SQUARE_EN
                    sq_d[i]   = ~sq_q[i];
`endif
                    if (mode_act_q[i]) begin
                        state_d[i] = S_DONE;
                        exp_d[i]   = 1'b1;
                    end else begin
                        cnt_d[i]      = per_new_c[i];
                        mode_act_d[i] = mode_new_c[i];
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] - WIDTH'(1);
                end
            end

            run_d[i] = (state_d[i] == S_RUN);
        end
    end

    // State and output registers
    always_ff @(posedge clock_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= S_IDLE;
                cnt_q[i]    <= '0;
                per_sh_q[i] <= RESET_PERIOD;
            end
            mode_sh_q  <= '0;
            mode_act_q <= '0;
            tick_q     <= '0;
            run_q      <= '0;
            exp_q      <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= state_d[i];
                cnt_q[i]    <= cnt_d[i];
                per_sh_q[i] <= per_sh_d[i];
            end
            mode_sh_q  <= mode_sh_d;
            mode_act_q <= mode_act_d;
            tick_q     <= tick_d;
            run_q      <= run_d;
            exp_q      <= exp_d;
        end
    end

`ifdef MULTI_TICK_TIMER_SQUARE_EN
    // Square-wave toggle flops
    always_ff @(posedge clock_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            sq_q <= '0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign square = sq_q;
`else
    assign square = '0;
`endif

    assign tick    = tick_q;
    assign running = run_q;
    assign expired = exp_q;

endmodule

// File: tb/tb_multi_tick_timer.sv
// Table-driven bench for multi_tick_timer: five channels, 8-bit counters,
// reset period 3. One vector per clock; outputs checked 1 ns after the edge.
module tb_multi_tick_timer;

    localparam int unsigned N  = 5;
    localparam int unsigned W  = 8;
    localparam int unsigned DP = 3;
    localparam int unsigned CW = 3;
`ifdef MULTI_TICK_TIMER_SQUARE_EN
    localparam bit SQ_EN = 1'b1;
`else
    localparam bit SQ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_we;
    logic [CW-1:0] cfg_chan;
    logic [W-1:0]  cfg_period;
    logic          cfg_mode;
    logic [N-1:0]  start;
    logic [N-1:0]  stop;
    logic [N-1:0]  tick;
    logic [N-1:0]  square;
    logic [N-1:0]  running;
    logic [N-1:0]  expired;

    always #5 clk = ~clk;

    multi_tick_timer #(
        .CHANNELS       (N),
        .WIDTH          (W),
        .DEFAULT_PERIOD (DP)
    ) dut (
        .clock_25mhz (clk),
        .reset_n     (reset_n),
        .cfg_we      (cfg_we),
        .cfg_chan    (cfg_chan),
        .cfg_period  (cfg_period),
        .cfg_mode    (cfg_mode),
        .start       (start),
        .stop        (stop),
        .tick        (tick),
        .square      (square),
        .running     (running),
        .expired     (expired)
    );

    typedef struct {
        logic [N-1:0]  st;
        logic [N-1:0]  sp;
        logic          we;
        logic [CW-1:0] ch;
        logic [W-1:0]  per;
        logic          md;
        logic [N-1:0]  tk;
        logic [N-1:0]  rn;
        logic [N-1:0]  ex;
    } vec_t;

    vec_t         tbl[$];
    int           errors = 0;
    int           checks = 0;
    logic [N-1:0] sq_m   = '0;

    task automatic push(input logic [N-1:0] st, input logic [N-1:0] sp, input logic we,
                        input logic [CW-1:0] ch, input logic [W-1:0] per, input logic md,
                        input logic [N-1:0] tk, input logic [N-1:0] rn, input logic [N-1:0] ex);
        vec_t v;
        v.st = st; v.sp = sp; v.we = we; v.ch = ch; v.per = per; v.md = md;
        v.tk = tk; v.rn = rn; v.ex = ex;
        tbl.push_back(v);
    endtask

    task automatic idle(input int n, input logic [N-1:0] tk, input logic [N-1:0] rn,
                        input logic [N-1:0] ex);
        for (int k = 0; k < n; k++) push('0, '0, 1'b0, '0, '0, 1'b0, tk, rn, ex);
    endtask

    task automatic cfg(input logic [CW-1:0] ch, input logic [W-1:0] per, input logic md);
        push('0, '0, 1'b1, ch, per, md, '0, '0, '0);
    endtask

    task automatic chk(input string nm, input int idx, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %b want %b", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_tick"},    -1, tick,    '0);
        chk({nm, "_running"}, -1, running, '0);
        chk({nm, "_expired"}, -1, expired, '0);
        chk({nm, "_square"},  -1, square,  '0);
    endtask

    task automatic run_vec(input int i);
        start      = tbl[i].st;
        stop       = tbl[i].sp;
        cfg_we     = tbl[i].we;
        cfg_chan   = tbl[i].ch;
        cfg_period = tbl[i].per;
        cfg_mode   = tbl[i].md;
        @(posedge clk);
        #1;
        sq_m = (sq_m ^ tbl[i].tk) & ~tbl[i].sp;
        chk("tick",    i, tick,    tbl[i].tk);
        chk("running", i, running, tbl[i].rn);
        chk("expired", i, expired, tbl[i].ex);
        chk("square",  i, square,  SQ_EN ? sq_m : '0);
    endtask

    int seg1_end;

    initial begin
        reset_n    = 1'b0;
        cfg_we     = 1'b0;
        cfg_chan   = '0;
        cfg_period = '0;
        cfg_mode   = 1'b0;
        start      = '0;
        stop       = '0;

        // ch0 periodic at reset period 3: ticks 4, 8, 12 cycles after start
        push(5'b00001, '0, 1'b0, '0, '0, 1'b0, '0, 5'b00001, '0);
        idle(3, '0, 5'b00001, '0);
        idle(1, 5'b00001, 5'b00001, '0);
        idle(3, '0, 5'b00001, '0);
        idle(1, 5'b00001, 5'b00001, '0);
        idle(3, '0, 5'b00001, '0);
        idle(1, 5'b00001, 5'b00001, '0);
        push('0, 5'b00001, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        // ch1 one-shot P=5: single tick 6 cycles after start, expired sticks
        cfg(3'd1, 8'd5, 1'b1);
        push(5'b00010, '0, 1'b0, '0, '0, 1'b0, '0, 5'b00010, '0);
        idle(5, '0, 5'b00010, '0);
        idle(1, 5'b00010, '0, 5'b00010);
        idle(2, '0, '0, 5'b00010);
        push(5'b00010, '0, 1'b0, '0, '0, 1'b0, '0, 5'b00010, '0);
        push('0, 5'b00010, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        // ch4: config write in the same cycle as start is used (P=1 one-shot)
        push(5'b10000, '0, 1'b1, 3'd4, 8'd1, 1'b1, '0, 5'b10000, '0);
        idle(1, '0, 5'b10000, '0);
        idle(1, 5'b10000, '0, 5'b10000);
        push('0, 5'b10000, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        // ch0 P=9, rewritten to P=2 mid-count: tick at 10, then every 3
        cfg(3'd0, 8'd9, 1'b0);
        push(5'b00001, '0, 1'b0, '0, '0, 1'b0, '0, 5'b00001, '0);
        push('0, '0, 1'b1, 3'd0, 8'd2, 1'b0, '0, 5'b00001, '0);
        idle(8, '0, 5'b00001, '0);
        idle(1, 5'b00001, 5'b00001, '0);
        idle(2, '0, 5'b00001, '0);
        idle(1, 5'b00001, 5'b00001, '0);
        idle(2, '0, 5'b00001, '0);
        idle(1, 5'b00001, 5'b00001, '0);
        push('0, 5'b00001, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        // ch2: start and stop together stays idle; stop on a due tick suppresses it
        push(5'b00100, 5'b00100, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        idle(4, '0, '0, '0);
        push(5'b00100, '0, 1'b0, '0, '0, 1'b0, '0, 5'b00100, '0);
        idle(3, '0, 5'b00100, '0);
        idle(1, 5'b00100, 5'b00100, '0);
        idle(3, '0, 5'b00100, '0);
        push('0, 5'b00100, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        idle(2, '0, '0, '0);
        // ch3 P=0 periodic: tick every cycle from cycle 1
        cfg(3'd3, 8'd0, 1'b0);
        push(5'b01000, '0, 1'b0, '0, '0, 1'b0, '0, 5'b01000, '0);
        idle(4, 5'b01000, 5'b01000, '0);
        seg1_end = tbl.size();

        // After reset: out-of-range write ignored, all channels back to period 3,
        // ch0 restarted mid-period loses its pending tick
        cfg(3'd5, 8'd0, 1'b1);
        push(5'b11111, '0, 1'b0, '0, '0, 1'b0, '0, 5'b11111, '0);
        idle(1, '0, 5'b11111, '0);
        push(5'b00001, '0, 1'b0, '0, '0, 1'b0, '0, 5'b11111, '0);
        idle(1, '0, 5'b11111, '0);
        idle(1, 5'b11110, 5'b11111, '0);
        idle(1, '0, 5'b11111, '0);
        idle(1, 5'b00001, 5'b11111, '0);
        idle(1, '0, 5'b11111, '0);
        idle(1, 5'b11110, 5'b11111, '0);
        push('0, 5'b11111, 1'b0, '0, '0, 1'b0, '0, '0, '0);

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("in_reset");
        reset_n = 1'b1;
        chk_all_zero("post_reset");

        for (int i = 0; i < seg1_end; i++) run_vec(i);

        // Asynchronous reset mid-run clears outputs without a clock edge
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        sq_m = '0;
        @(posedge clk);
        #1;
        chk_all_zero("held_reset");
        reset_n = 1'b1;

        for (int i = seg1_end; i < tbl.size(); i++) run_vec(i);

        start  = '0;
        stop   = '0;
        cfg_we = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_tick_timer.md
# multi_tick_timer

Parametrised multi-channel tick generator replacing the fixed divide-by-N clock generation in the HeartAware top level. Each of CHANNELS independent channels counts down a programmable period on the single `clock_25mhz` domain and emits a one-cycle `tick` enable strobe, an optional divided square wave, and run/expired status. Channels run either periodically, replacing the 1 Hz divider, or in one-shot mode, replacing the anti-theft countdown timer. Consumers use `tick` as a clock enable; no derived clocks are generated.

## Interface
- `CHANNELS`, 4: number of independent channels (1..16).
- `WIDTH`, 24: counter and period width in bits.
- `DEFAULT_PERIOD`, 12_499_999: reset value of every channel's period register; must fit in WIDTH.
- `clock_25mhz`  in  1: system clock, all logic on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `cfg_we`  in  1: config write strobe, one cycle.
- `cfg_chan`  in  $clog2(CHANNELS), minimum 1: target channel of the write.
- `cfg_period`  in  WIDTH: terminal count P; the channel period is P+1 cycles.
- `cfg_mode`  in  1: 0 = periodic, 1 = one-shot.
- `start`  in  CHANNELS: per-channel start/restart pulse.
- `stop`  in  CHANNELS: per-channel stop pulse.
- `tick`  out  CHANNELS: one-cycle strobe at each period end.
- `square`  out  CHANNELS: toggles on every tick.
- `running`  out  CHANNELS: channel is in RUN.
- `expired`  out  CHANNELS: sticky one-shot completion flag.

## Operation
- Per-channel registers:
  - period shadow `per_sh` and mode shadow `mode_sh`, written by cfg.
  - active copies `per_act` and `mode_act`, loaded from the shadows on start and on every periodic reload.
  - down-counter `cnt` (WIDTH bits).
  - state: IDLE, RUN, DONE.
- Config write:
  - On `cfg_we`, `per_sh[cfg_chan]` ← `cfg_period` and `mode_sh[cfg_chan]` ← `cfg_mode`.
  - A write with `cfg_chan` ≥ CHANNELS is ignored.
  - A write never disturbs a running count; it takes effect at the next start or reload.
- IDLE or DONE with `start`: load the active copies from the shadows (a same-cycle cfg write to this channel is included), set `cnt` ← new period, clear `expired`, go to RUN.
- RUN with `cnt` ≠ 0: decrement `cnt`.
- RUN with `cnt` == 0:
  - Assert `tick` on the next cycle and toggle `square`.
  - Periodic mode: reload the active copies from the shadows and set `cnt` to the new period. Stay in RUN.
  - One-shot mode: set `expired` together with the tick and go to DONE.
- RUN with `start`: restart. Reload the counter as from IDLE; no tick is produced for the aborted period.
- `stop` in any state: go to IDLE, clear `cnt`, `expired` and `square`. No tick is produced.
- `start` and `stop` asserted in the same cycle: `stop` wins.
- `start` on several channels in the same cycle: each channel acts independently.
- P = 0: periodic mode holds `tick` high continuously (a tick every cycle) and `square` toggles every cycle. One-shot mode gives exactly one tick.
- `running` = (state == RUN). `expired` remains high in DONE until the next `start` or `stop`.
- Counter arithmetic is unsigned WIDTH-bit. Because reload happens at 0, the counter never wraps.

## Timing
- Reset (`reset_n` low, asynchronous):
  - `tick`, `square`, `running`, `expired` = 0.
  - `cnt` = 0, state IDLE.
  - `per_sh` and `per_act` = DEFAULT_PERIOD; `mode_sh` and `mode_act` = 0.
- Reset deasserted mid-count: all channels return to IDLE; nothing resumes.
- Outputs are registered; there is no combinational path from inputs to outputs.
- `start` sampled at edge k:
  - `running` goes high after edge k.
  - The first `tick` is high for the cycle following edge k+P+1.
  - Subsequent ticks occur every P+1 cycles.
- `stop` sampled at edge k: all outputs for that channel are low after edge k. A tick already scheduled for that edge is suppressed.
- A cfg write at edge k followed by `start` at edge k+1 uses the new period.

## Configuration
- `MULTI_TICK_TIMER_SQUARE_EN`
  - Defined: the `square` toggle flops are instantiated and behave as described above.
  - Undefined: no square flops are built, `square` is tied to 0, and all other behaviour is identical.

## Test plan
- Reset, then `start[0]` with DEFAULT_PERIOD overridden to P=3 → `tick[0]` high at cycles 4, 8, 12 after start; `square[0]` toggles 1, 0, 1; `running[0]` stays 1.
- Write ch1 with P=5 and mode 1, then `start[1]` → exactly one tick 6 cycles after start. `expired[1]`=1 and `running[1]`=0 from that cycle on. A second `start[1]` clears `expired`.
- Ch0 running with P=9; write P=2 mid-count → the current period still ends 10 cycles after start; the following ticks are 3 cycles apart.
- `start[2]` and `stop[2]` in the same cycle → ch2 stays IDLE with no tick. `stop` on the cycle before a due tick → no tick, and `square` is 0.
- P=0, periodic on ch3 → `tick[3]` high on every cycle from cycle 1. Pull `reset_n` low mid-run → all outputs go 0 immediately; after release the period equals DEFAULT_PERIOD.
- `cfg_we` with `cfg_chan`=CHANNELS (when CHANNELS is not a power of two, e.g. 3) → no shadow register changes. Build without `MULTI_TICK_TIMER_SQUARE_EN` → `square` is constant 0 while ticks are unchanged.
